// File: rtl/reset_seq_pkg.sv
// Shared state type and elaboration helpers for the staggered multi-domain reset sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        IN_RESET = 2'd0,
        HOLD     = 2'd1,
        RELEASE  = 2'd2,
        DONE     = 2'd3
    } rst_seq_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// Reset synchronizer: asynchronously set by async_reset_n, cleared one stage per clk after release.
module reset_sync_chain
    import reset_seq_pkg::*;
#(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic async_reset_n,
    output logic sync_reset_o
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            r_chain <= '1;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], 1'b0};
        end
    end

    assign sync_reset_o = r_chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staggered reset controller: async assert, synchronous per-domain release, soft-reset restart.
// RST_GLOBAL_BUF_EN routes every reset output and the synchronised reset through a BUFG.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 3,
    parameter int NUM_DOMAINS = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int RELEASE_GAP = 4
) (
    input  logic                   clk,
    input  logic                   async_reset_n,
    input  logic                   soft_reset_req,
    output logic [NUM_DOMAINS-1:0] sync_reset,
    output logic                   reset_done
);

    localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, RELEASE_GAP) + 1);
    localparam int IDX_W = $clog2(NUM_DOMAINS + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(RELEASE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("reset_sequencer: SYNC_STAGES must be >= 2");
        end
        if (NUM_DOMAINS < 1) begin : g_bad_domains
            $error("reset_sequencer: NUM_DOMAINS must be >= 1");
        end
        if (HOLD_CYCLES < 1) begin : g_bad_hold
            $error("reset_sequencer: HOLD_CYCLES must be >= 1");
        end
        if (RELEASE_GAP < 1) begin : g_bad_gap
            $error("reset_sequencer: RELEASE_GAP must be >= 1");
        end
    endgenerate

    logic                   w_sync_rst_raw;
    logic                   w_sync_rst;
    rst_seq_state_t         r_state;
    rst_seq_state_t         w_state_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_next;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       w_idx_next;
    logic                   r_done;
    logic                   w_done_next;
    logic                   w_soft;
    logic                   w_release;
    logic [NUM_DOMAINS-1:0] r_sync_reset;

    reset_sync_chain #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk          (clk),
        .async_reset_n(async_reset_n),
        .sync_reset_o (w_sync_rst_raw)
    );

`ifdef RST_GLOBAL_BUF_EN
    BUFG u_bufg_sync (.I(w_sync_rst_raw), .O(w_sync_rst));
`else
    assign w_sync_rst = w_sync_rst_raw;
`endif

    // A soft request only counts once the sequence has left IN_RESET.
    assign w_soft = soft_reset_req && (r_state != IN_RESET);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_done_next  = r_done;
        w_release    = 1'b0;
        if (w_soft) begin
            w_state_next = HOLD;
            w_cnt_next   = '0;
            w_idx_next   = '0;
            w_done_next  = 1'b0;
        end else begin
            case (r_state)
                IN_RESET: begin
                    w_cnt_next = '0;
                    if (!w_sync_rst) begin
                        w_state_next = HOLD;
                    end
                end
                HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        w_release  = 1'b1;
                        w_cnt_next = '0;
                        w_idx_next = IDX_W'(1);
                        if (NUM_DOMAINS == 1) begin
                            w_state_next = DONE;
                            w_done_next  = 1'b1;
                        end else begin
                            w_state_next = RELEASE;
                        end
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (r_cnt == GAP_LAST) begin
                        w_release  = 1'b1;
                        w_cnt_next = '0;
                        w_idx_next = r_idx + IDX_W'(1);
                        if (r_idx == IDX_LAST) begin
                            w_state_next = DONE;
                            w_done_next  = 1'b1;
                        end
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            r_state <= IN_RESET;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_done  <= w_done_next;
        end
    end

    // r_idx is 0 throughout HOLD, so one index compare covers both release paths.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DOMAINS; gi++) begin : g_dom
            always_ff @(posedge clk or negedge async_reset_n) begin
                if (!async_reset_n) begin
                    r_sync_reset[gi] <= 1'b1;
                end else if (w_soft) begin
                    r_sync_reset[gi] <= 1'b1;
                end else if (w_release && (r_idx == IDX_W'(gi))) begin
                    r_sync_reset[gi] <= 1'b0;
                end
            end
`ifdef RST_GLOBAL_BUF_EN
            BUFG u_bufg_dom (.I(r_sync_reset[gi]), .O(sync_reset[gi]));
`else
            assign sync_reset[gi] = r_sync_reset[gi];
`endif
        end
    endgenerate

    assign reset_done = r_done;

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomised self-checking bench: two sequencer configurations against an edge-arithmetic model.
module tb_reset_sequencer;

    localparam int S0 = 3, N0 = 4, H0 = 8, G0 = 4;
    localparam int S1 = 2, N1 = 1, H1 = 1, G1 = 4;

    logic          clk = 1'b0;
    logic          async_reset_n = 1'b1;
    logic          soft_reset_req = 1'b0;
    logic [N0-1:0] sync_reset0;
    logic          done0;
    logic [N1-1:0] sync_reset1;
    logic          done1;

    int n_vec = 0;
    int n_err = 0;
    int e = 0;      // edges since async release
    int a0 = -1;    // edge at which the current HOLD began (-1: still in IN_RESET)
    int a1 = -1;
    bit po_tbl = 1'b0;
    int burst = 0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .SYNC_STAGES(S0), .NUM_DOMAINS(N0), .HOLD_CYCLES(H0), .RELEASE_GAP(G0)
    ) u_dut0 (
        .clk           (clk),
        .async_reset_n (async_reset_n),
        .soft_reset_req(soft_reset_req),
        .sync_reset    (sync_reset0),
        .reset_done    (done0)
    );

    reset_sequencer #(
        .SYNC_STAGES(S1), .NUM_DOMAINS(N1), .HOLD_CYCLES(H1), .RELEASE_GAP(G1)
    ) u_dut1 (
        .clk           (clk),
        .async_reset_n (async_reset_n),
        .soft_reset_req(soft_reset_req),
        .sync_reset    (sync_reset1),
        .reset_done    (done1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (edge %0d, t=%0t)", tag, got, exp, e, $time);
        end
    endtask

    function automatic logic [31:0] exp_rst(input int anchor, input int n, input int h, input int g);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n; i++) begin
            v[i] = !(anchor >= 0 && e >= anchor + h + i * g);
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_done(input int anchor, input int n, input int h, input int g);
        return {31'b0, (anchor >= 0 && e >= anchor + h + (n - 1) * g)};
    endfunction

    // Power-on timing table for both configurations, written out as absolute edges.
    function automatic logic [31:0] po_rst0();
        if (e < 12)      return 32'hF;
        else if (e < 16) return 32'hE;
        else if (e < 20) return 32'hC;
        else if (e < 24) return 32'h8;
        else             return 32'h0;
    endfunction

    task automatic check_all();
        check("dom4_rst",  {28'b0, sync_reset0}, exp_rst(a0, N0, H0, G0));
        check("dom4_done", {31'b0, done0},       exp_done(a0, N0, H0, G0));
        check("dom1_rst",  {31'b0, sync_reset1}, exp_rst(a1, N1, H1, G1));
        check("dom1_done", {31'b0, done1},       exp_done(a1, N1, H1, G1));
        if (po_tbl) begin
            check("po_tbl_rst4",  {28'b0, sync_reset0}, po_rst0());
            check("po_tbl_done4", {31'b0, done0},       {31'b0, e >= 24});
            check("po_tbl_rst1",  {31'b0, sync_reset1}, {31'b0, e < 4});
            check("po_tbl_done1", {31'b0, done1},       {31'b0, e >= 4});
        end
    endtask

    task automatic step(input logic rn, input logic sr);
        async_reset_n  = rn;
        soft_reset_req = sr;
        if (!rn) begin
            e  = 0;
            a0 = -1;
            a1 = -1;
            #1;
            check_all();
        end
        @(posedge clk);
        if (rn) begin
            e++;
            if (a0 >= 0 && sr)           a0 = e;
            else if (a0 < 0 && e == S0 + 1) a0 = e;
            if (a1 >= 0 && sr)           a1 = e;
            else if (a1 < 0 && e == S1 + 1) a1 = e;
        end
        @(negedge clk);
        check_all();
    endtask

    // Short async pulse between two edges; no clock edge occurs while it is low.
    task automatic pulse();
        async_reset_n = 1'b0;
        e  = 0;
        a0 = -1;
        a1 = -1;
        #1;
        check_all();
        #1;
        async_reset_n = 1'b1;
    endtask

    initial begin
        #2;

        po_tbl = 1'b1;
        repeat (5) step(1'b0, 1'b0);
        while (e < 30) step(1'b1, 1'b0);
        $display("power-on sequence: edges 1..%0d checked", e);

        step(1'b0, 1'b0);
        while (e < 17) step(1'b1, 1'b0);
        pulse();
        while (e < 30) step(1'b1, 1'b0);
        $display("async pulse between edges 17 and 18: restart checked to edge %0d", e);

        po_tbl = 1'b0;
        repeat (2) step(1'b0, 1'b0);
        while (e < 64) begin
            step(1'b1, (e + 1) == 40);
            if (e == 47) check("soft40_e47", {28'b0, sync_reset0}, 32'hF);
            if (e == 48) check("soft40_e48", {28'b0, sync_reset0}, 32'hE);
            if (e == 59) check("soft40_e59_done", {31'b0, done0}, 32'h0);
            if (e == 60) check("soft40_e60_done", {31'b0, done0}, 32'h1);
        end
        $display("soft request at edge 40 in DONE: checked to edge %0d", e);

        repeat (2) step(1'b0, 1'b0);
        while (e < 45) begin
            step(1'b1, ((e + 1) >= 14) && ((e + 1) <= 23));
            if (e == 30) check("softhold_e30", {28'b0, sync_reset0}, 32'hF);
            if (e == 31) check("softhold_e31", {28'b0, sync_reset0}, 32'hE);
        end
        $display("soft request held edges 14..23: checked to edge %0d", e);

        po_tbl = 1'b1;
        repeat (3) step(1'b0, 1'b0);
        while (e < 30) step(1'b1, (e + 1) == 2);
        po_tbl = 1'b0;
        $display("soft request during IN_RESET: checked to edge %0d", e);

        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        for (int k = 0; k < 3000; k++) begin
            int r;
            r = int'($urandom_range(0, 199));
            if (burst == 0 && $urandom_range(0, 39) == 0) burst = int'($urandom_range(1, 12));
            if (r < 3) begin
                pulse();
            end else if (r < 6) begin
                step(1'b0, 1'($urandom_range(0, 1)));
            end else begin
                step(1'b1, burst > 0);
            end
            if (burst > 0) burst--;
        end
        $display("random phase: 3000 cycles applied");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
